// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard/stall bundle between the core pipeline and pipe_stall_ctrl
//
// Purpose: groups the hazard inputs, pipeline stall/flush enables, MUL/DIV
// handshake and performance counters used by pipe_stall_ctrl.
//
// Signals (direction seen from the slave, i.e. pipe_stall_ctrl):
//   in : rs1_addr_D, rs2_addr_D, RdE, MemReadE, PCSrcE, MdValidE, md_done
//   out: StallF, StallD, StallE, FlushD, FlushE, FlushM,
//        md_start, md_abort, md_err, stall_cnt, md_cnt, flush_cnt
//
// CNT_W must match the CNT_W of the pipe_stall_ctrl instance.

interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_addr_D;
  logic [4:0]       rs2_addr_D;
  logic [4:0]       RdE;
  logic             MemReadE;
  logic             PCSrcE;
  logic             MdValidE;
  logic             md_done;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             md_start;
  logic             md_abort;
  logic             md_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_addr_D, rs2_addr_D, RdE, MemReadE, PCSrcE, MdValidE, md_done,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  md_start, md_abort, md_err, stall_cnt, md_cnt, flush_cnt
  );

  modport slave (
    input  rs1_addr_D, rs2_addr_D, RdE, MemReadE, PCSrcE, MdValidE, md_done,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output md_start, md_abort, md_err, stall_cnt, md_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush sequencer for load-use, branch and MUL/DIV hazards
//
// Purpose: drives the stall and flush enables of the IF/ID, ID/EX and EX/MEM
// pipeline registers for hazards that forwarding cannot resolve, and runs
// the issue/wait/timeout handshake with the shared MUL/DIV unit.
//
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - pipe_stall_ctrl_if.slave: hazard inputs, stall/flush outputs,
//          MUL/DIV handshake, performance counters
//
// Parameters:
//   MD_TIMEOUT - max cycles spent in MD_WAIT before the op is aborted (>= 2)
//   CNT_W      - performance counter width
//
// Optional feature macro: PERF_CNT_EN builds saturating counters for
// load-use stall cycles, MD_WAIT cycles and branch flushes. Without it the
// counter outputs are tied to zero.

module pipe_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int TO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            err_q, err_d;

  logic lu;
  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;
  logic md_start, md_abort;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = bus.MemReadE && (bus.RdE != 5'd0) &&
              ((bus.RdE == bus.rs1_addr_D) || (bus.RdE == bus.rs2_addr_D));

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    md_start = 1'b0;
    md_abort = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.MdValidE) begin
          md_start = 1'b1;
          state_d  = MD_WAIT;
          tcnt_d   = '0;
        end else if (bus.PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lu) begin
          // One bubble: hold F/D and squash E. The next cycle sees the load
          // in M, so lu drops by itself.
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      MD_WAIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        if (bus.md_done) begin
          // Result is valid this cycle: let it advance into M and release
          // the front end together with it.
          stall_f = 1'b0;
          stall_d = 1'b0;
          stall_e = 1'b0;
          flush_m = 1'b0;
          state_d = RUN;
        end else if (tcnt_q == TO_LAST) begin
          // Abort: the MD op leaves E but M stays a bubble, since the
          // result is undefined. md_err tells software.
          stall_e  = 1'b0;
          md_abort = 1'b1;
          err_d    = 1'b1;
          state_d  = RUN;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.StallF   = stall_f;
  assign bus.StallD   = stall_d;
  assign bus.StallE   = stall_e;
  assign bus.FlushD   = flush_d;
  assign bus.FlushE   = flush_e;
  assign bus.FlushM   = flush_m;
  assign bus.md_start = md_start;
  assign bus.md_abort = md_abort;
  assign bus.md_err   = err_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_stall;
  logic             br_flush;
  logic             in_wait;

  // Counters stop at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  // Load-use stall and branch flush only count when they actually win
  // the RUN priority decode.
  assign lu_stall = (state_q == RUN) && !bus.MdValidE && !bus.PCSrcE && lu;
  assign br_flush = (state_q == RUN) && !bus.MdValidE && bus.PCSrcE;
  assign in_wait  = (state_q == MD_WAIT);

  assign stall_cnt_d = sat_inc(stall_cnt_q, lu_stall);
  assign md_cnt_d    = sat_inc(md_cnt_q, in_wait);
  assign flush_cnt_d = sat_inc(flush_cnt_q, br_flush);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      md_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      md_cnt_q    <= md_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.md_cnt    = md_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.md_cnt    = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl

module tb_pipe_stall_ctrl;

  localparam int TB_TO    = 8;
  localparam int TB_CNT_W = 4;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector: {StallF,StallD,StallE,FlushD,FlushE,FlushM,md_start,md_abort,md_err}
  localparam logic [8:0] O_IDLE  = 9'b000_000_000;
  localparam logic [8:0] O_LU    = 9'b110_010_000;
  localparam logic [8:0] O_BR    = 9'b000_110_000;
  localparam logic [8:0] O_START = 9'b000_000_100;
  localparam logic [8:0] O_WAIT  = 9'b111_001_000;
  localparam logic [8:0] O_DONE  = 9'b000_000_000;
  localparam logic [8:0] O_ABORT = 9'b110_001_010;
  localparam logic [8:0] O_ERR   = 9'b000_000_001;

  typedef struct {
    logic [8:0]          o;
    bit                  chk_cnt;
    logic [TB_CNT_W-1:0] sc;
    logic [TB_CNT_W-1:0] mc;
    logic [TB_CNT_W-1:0] fc;
    string               tag;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  pipe_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MD_TIMEOUT(TB_TO),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TB_CNT_W-1:0] pc(input int v);
    return PERF ? TB_CNT_W'(v) : '0;
  endfunction

  // Monitor: pops one expectation per cycle, sampled at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = sb.pop_front();
      act = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE,
             bus.FlushM, bus.md_start, bus.md_abort, bus.md_err};
      checks++;
      if (act !== e.o) begin
        failures++;
        $display("FAIL %s outputs: got %b expected %b", e.tag, act, e.o);
      end
      if (e.chk_cnt) begin
        checks++;
        if ({bus.stall_cnt, bus.md_cnt, bus.flush_cnt} !== {e.sc, e.mc, e.fc}) begin
          failures++;
          $display("FAIL %s counters: got s=%0d m=%0d f=%0d expected s=%0d m=%0d f=%0d",
                   e.tag, bus.stall_cnt, bus.md_cnt, bus.flush_cnt, e.sc, e.mc, e.fc);
        end
      end
    end
  end

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic br,
                        input logic mdv, input logic done);
    bus.rs1_addr_D = rs1;
    bus.rs2_addr_D = rs2;
    bus.RdE        = rd;
    bus.MemReadE   = mr;
    bus.PCSrcE     = br;
    bus.MdValidE   = mdv;
    bus.md_done    = done;
  endtask

  task automatic push(input logic [8:0] o, input string tag, input bit c,
                      input int sc, input int mc, input int fc);
    exp_t e;
    e.o = o; e.tag = tag; e.chk_cnt = c;
    e.sc = pc(sc); e.mc = pc(mc); e.fc = pc(fc);
    sb.push_back(e);
  endtask

  task automatic step(input logic [8:0] o, input string tag);
    push(o, tag, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic stepc(input logic [8:0] o, input string tag,
                       input int sc, input int mc, input int fc);
    push(o, tag, 1'b1, sc, mc, fc);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    stepc(O_IDLE, "reset", 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // 1. load-use via rs2, one bubble
    do_reset();
    set_in(0, 5, 5, 1, 0, 0, 0);  stepc(O_LU,   "lu_rs2", 0, 0, 0);
    set_in(0, 5, 5, 0, 0, 0, 0);  stepc(O_IDLE, "lu_release", 1, 0, 0);

    // 2. x0, no dependency, branch beats load-use, rs1 load-use
    do_reset();
    set_in(0, 0, 0, 1, 0, 0, 0);  step(O_IDLE, "x0_no_stall");
    set_in(4, 5, 9, 1, 0, 0, 0);  step(O_IDLE, "no_dep");
    set_in(4, 4, 4, 0, 0, 0, 0);  step(O_IDLE, "dep_not_load");
    set_in(7, 3, 7, 1, 1, 0, 0);  stepc(O_BR,  "branch_over_lu", 0, 0, 0);
    set_in(7, 3, 7, 1, 0, 0, 0);  stepc(O_LU,  "lu_rs1", 0, 0, 1);
    set_in(0, 0, 0, 0, 0, 0, 0);  stepc(O_IDLE, "cnt_after_br_lu", 1, 0, 1);

    // 3. MUL/DIV handshake, back-to-back issue, md_done ignored in RUN
    do_reset();
    set_in(7, 3, 7, 1, 1, 1, 0);  stepc(O_START, "md_issue_over_br", 0, 0, 0);
    set_in(7, 3, 7, 1, 1, 1, 0);  step(O_WAIT, "md_wait1_ignores");
    set_in(0, 0, 0, 0, 0, 0, 0);  step(O_WAIT, "md_wait2");
    step(O_WAIT, "md_wait3");
    set_in(0, 0, 0, 0, 0, 0, 1);  step(O_DONE, "md_done");
    set_in(0, 0, 0, 0, 0, 1, 0);  stepc(O_START, "md_back_to_back", 0, 4, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);  step(O_DONE, "md_done_fast");
    set_in(0, 0, 0, 0, 0, 0, 1);  stepc(O_IDLE, "md_done_in_run", 0, 5, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);  step(O_IDLE, "run_idle");

    // 4a. timeout: abort in the 8th MD_WAIT cycle, md_err sticky
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0);  step(O_START, "to_issue");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TB_TO - 1; i++) step(O_WAIT, "to_wait");
    step(O_ABORT, "to_abort");
    stepc(O_IDLE | O_ERR, "to_err_set", 0, 8, 0);
    step(O_IDLE | O_ERR, "to_err_sticky");

    // 4b. md_done on the expiry cycle wins
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0);  step(O_START, "tod_issue");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TB_TO - 1; i++) step(O_WAIT, "tod_wait");
    set_in(0, 0, 0, 0, 0, 0, 1);  step(O_DONE, "tod_done_wins");
    set_in(0, 0, 0, 0, 0, 0, 0);  stepc(O_IDLE, "tod_no_err", 0, 8, 0);

    // 5. async reset in MD_WAIT with md_err set
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0);  step(O_START, "ar_issue");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TB_TO - 1; i++) step(O_WAIT, "ar_wait");
    step(O_ABORT, "ar_abort");
    step(O_IDLE | O_ERR, "ar_err");
    set_in(0, 0, 0, 0, 0, 1, 0);  step(O_START | O_ERR, "ar_issue2");
    set_in(0, 0, 0, 0, 0, 0, 0);  step(O_WAIT | O_ERR, "ar_wait2");
    push(O_IDLE, "ar_async_reset", 1'b1, 0, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 1, 0);  step(O_START, "ar_reissue");
    set_in(0, 0, 0, 0, 0, 0, 1);  step(O_DONE, "ar_done");
    set_in(0, 0, 0, 0, 0, 0, 0);  stepc(O_IDLE, "ar_after", 0, 1, 0);

    // 6. stall_cnt saturation with a held load-use
    do_reset();
    set_in(5, 0, 5, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      stepc(O_LU, "sat_lu", (i > 15) ? 15 : i, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);  stepc(O_IDLE, "sat_hold", 15, 0, 0);

    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
